// File: rtl/jogo_memoria_param.sv
// Memory-challenge game core: the player repeats a programmable button sequence,
// one entry more per round, with an optional per-jogada timeout.
module jogo_memoria_param #(
  parameter int N_BOTOES       = 4,
  parameter int MAX_RODADAS    = 16,
  parameter int AW             = 4,
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                timeout_en,
  input  logic                seq_we,
  input  logic [AW-1:0]       seq_addr,
  input  logic [N_BOTOES-1:0] seq_data,
  output logic                ganhou,
  output logic                perdeu,
  output logic                timeout,
  output logic                pronto,
  output logic [N_BOTOES-1:0] leds,
  output logic [AW-1:0]       rodada,
  output logic [3:0]          db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS) + 1;
  localparam int MW = (MAX_RODADAS > 1) ? $clog2(MAX_RODADAS) : 1;
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW-1:0] ULTIMA    = AW'(MAX_RODADAS - 1);

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARA     = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] COMPARA     = 4'h3;
  localparam logic [3:0] PROX_JOGADA = 4'h4;
  localparam logic [3:0] PROX_RODADA = 4'h5;
  localparam logic [3:0] FIM_GANHOU  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_PERDEU  = 4'hE;

  logic [3:0]          estado, prox;
  logic [AW-1:0]       endereco;
  logic [TW-1:0]       timer;
  logic [N_BOTOES-1:0] botoes_prev;
  logic [N_BOTOES-1:0] mem [MAX_RODADAS];
  logic [N_BOTOES-1:0] mem_rd;
  logic                jogada, em_fim, pode_gravar;

  assign jogada = (|botoes) && !(|botoes_prev);
  assign em_fim = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
  // The pattern may only change while no game is in progress.
  assign pode_gravar = seq_we && (estado == INICIAL || em_fim) && (int'(seq_addr) < MAX_RODADAS);
  assign mem_rd = mem[endereco[MW-1:0]];

  // Sequence storage survives reset so a pattern can be replayed after a restart.
  always_ff @(posedge clock) begin
    if (pode_gravar) mem[seq_addr[MW-1:0]] <= seq_data;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (iniciar) prox = PREPARA;
      PREPARA:     prox = ESPERA;
      ESPERA: begin
        if (jogada) prox = COMPARA;
        else if (timeout_en && timer == TIMER_LIM) prox = FIM_TIMEOUT;
      end
      COMPARA: begin
        if (leds != mem_rd)          prox = FIM_PERDEU;
        else if (endereco < rodada)  prox = PROX_JOGADA;
        else if (rodada == ULTIMA)   prox = FIM_GANHOU;
        else                         prox = PROX_RODADA;
      end
      PROX_JOGADA: prox = ESPERA;
      PROX_RODADA: prox = ESPERA;
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (iniciar) prox = PREPARA;
      default:     prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= INICIAL;
      rodada      <= '0;
      endereco    <= '0;
      timer       <= '0;
      leds        <= '0;
      botoes_prev <= '0;
    end else begin
      estado      <= prox;
      botoes_prev <= botoes;
      case (estado)
        PREPARA: begin
          rodada   <= '0;
          endereco <= '0;
          timer    <= '0;
          leds     <= '0;
        end
        ESPERA: begin
          if (jogada) begin
            leds  <= botoes;
            timer <= '0;
          end else if (timer != TIMER_LIM) begin
            timer <= timer + 1'b1;
          end
        end
        PROX_JOGADA: endereco <= endereco + 1'b1;
        PROX_RODADA: begin
          rodada   <= rodada + 1'b1;
          endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  assign ganhou    = (estado == FIM_GANHOU);
  assign perdeu    = (estado == FIM_PERDEU);
  assign timeout   = (estado == FIM_TIMEOUT);
  assign pronto    = em_fim;
  assign db_estado = estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: win, error, timeout, held-button, restart and reset scenarios.
module tb_jogo_memoria_param;
  localparam int W = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'b0;
  logic       timeout_en = 1'b0;
  logic       seq_we = 1'b0;
  logic [3:0] seq_addr = 4'b0;
  logic [3:0] seq_data = 4'b0;
  logic       ganhou, perdeu, timeout, pronto;
  logic [3:0] leds, rodada, db_estado;
  logic [W-1:0] obs;
  logic [W-1:0] exp_q[$];
  logic [3:0] seq_tab [4];
  int total = 0;
  int bad = 0;

  jogo_memoria_param #(.N_BOTOES(4), .MAX_RODADAS(4), .AW(4), .TIMEOUT_CICLOS(20)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .timeout_en(timeout_en), .seq_we(seq_we), .seq_addr(seq_addr), .seq_data(seq_data),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto),
    .leds(leds), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  assign obs = {ganhou, perdeu, timeout, pronto, db_estado, rodada, leds};

  // Expected observation word built from state code, round and leds.
  function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [3:0] rod, input logic [3:0] ld);
    logic g, p, t;
    g = (st == 4'hA);
    p = (st == 4'hE);
    t = (st == 4'hD);
    return {g, p, t, (g | p | t), st, rod, ld};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start();
    iniciar = 1'b1;
    step();
    chk("prepara", {12'b0, db_estado}, 16'h0001);
    iniciar = 1'b0;
    step();
    chk("espera_entry", obs, mk(4'h2, 4'h0, 4'h0));
  endtask

  // 3 cycles high, 3 cycles low; result state checked one edge after COMPARA.
  task automatic press(input logic [3:0] val, input logic [3:0] st, input logic [3:0] rod);
    exp_q.push_back(mk(st, rod, val));
    botoes = val;
    step();
    chk("compara", obs, mk(4'h3, rod, val));
    step();
    chk("result", obs, exp_q.pop_front());
    step();
    botoes = 4'b0;
    repeat (3) step();
  endtask

  task automatic write_seq(input logic [3:0] addr, input logic [3:0] data);
    seq_we   = 1'b1;
    seq_addr = addr;
    seq_data = data;
    step();
    seq_we = 1'b0;
  endtask

  initial begin
    seq_tab[0] = 4'b0001;
    seq_tab[1] = 4'b0010;
    seq_tab[2] = 4'b0100;
    seq_tab[3] = 4'b1000;
    repeat (2) step();
    chk("reset_state", obs, 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) write_seq(4'(i), seq_tab[i]);

    // Full win
    start();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j <= r; j++) begin
        if (j < r)       press(seq_tab[j], 4'h4, 4'(r));
        else if (r == 3) press(seq_tab[j], 4'hA, 4'(r));
        else             press(seq_tab[j], 4'h5, 4'(r));
      end
    end
    chk("win_final", obs, mk(4'hA, 4'h3, 4'b1000));

    // Error in round 1
    start();
    press(4'b0001, 4'h5, 4'h0);
    press(4'b0001, 4'h4, 4'h1);
    press(4'b0100, 4'hE, 4'h1);
    chk("lose_hold", obs, mk(4'hE, 4'h1, 4'b0100));

    // Timeout enforced
    timeout_en = 1'b1;
    start();
    repeat (19) step();
    chk("pre_timeout", obs, mk(4'h2, 4'h0, 4'h0));
    step();
    chk("timeout", obs, mk(4'hD, 4'h0, 4'h0));

    // Timeout disabled
    timeout_en = 1'b0;
    start();
    repeat (100) step();
    chk("no_timeout", obs, mk(4'h2, 4'h0, 4'h0));

    // Asynchronous reset from ESPERA
    #2 reset = 1'b1;
    #1 chk("async_reset_espera", obs, 16'h0000);
    step();
    reset = 1'b0;

    // Button held across start is not a jogada
    botoes = 4'b0001;
    start();
    repeat (3) step();
    chk("held_ignored", obs, mk(4'h2, 4'h0, 4'h0));
    botoes = 4'b0;
    step();
    press(4'b0001, 4'h5, 4'h0);
    press(4'b0011, 4'hE, 4'h1);

    // Reprogram from FIM_PERDEU and restart
    write_seq(4'h0, 4'b1000);
    start();
    press(4'b1000, 4'h5, 4'h0);
    write_seq(4'h1, 4'b0001);
    chk("we_in_espera_state", obs, mk(4'h2, 4'h1, 4'b1000));
    press(4'b1000, 4'h4, 4'h1);
    press(4'b0010, 4'h5, 4'h1);
    press(4'b1000, 4'h4, 4'h2);

    // Reset mid-round 2, no clock edge needed
    #2 reset = 1'b1;
    #1 chk("async_reset_round2", obs, 16'h0000);
    step();
    reset = 1'b0;
    start();
    press(4'b1000, 4'h5, 4'h0);

    chk("queue_empty", W'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
